pe_dot_seq: RTL and testbench

//  Bus master that sits directly upstream of the memory-mapped PE wrapper and drives its

---
 rtl/pe_seq_pkg.sv | 50 +++++
 rtl/pe_dot_seq.sv | 203 ++++++++++++++++++++
 tb/tb_pe_dot_seq.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_seq_pkg.sv
// Shared constants for the PE dot-product sequencer: PE register map,
// CTRL/STATUS bit positions and the sequencer state encoding.
package pe_seq_pkg;

  localparam logic [2:0] ADDR_A    = 3'd0;
  localparam logic [2:0] ADDR_B    = 3'd1;
  localparam logic [2:0] ADDR_CTRL = 3'd2;
  localparam logic [2:0] ADDR_THR  = 3'd3;
  localparam logic [2:0] ADDR_DATA = 3'd4;
  localparam logic [2:0] ADDR_BIT  = 3'd5;
  localparam logic [2:0] ADDR_ACC  = 3'd6;

  localparam int CTRL_START  = 0;
  localparam int CTRL_MODE   = 1;
  localparam int CTRL_CLR    = 2;
  localparam int CTRL_RELU   = 3;
  localparam int CTRL_BITSEL = 4;

  localparam int STATUS_VLD_BIT = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG,
    S_CLR,
    S_WAIT_OP,
    S_WR_A,
    S_WR_B,
    S_START,
    S_POLL,
    S_DRAIN,
    S_RD_D,
    S_RD_B,
    S_RESP
  } state_e;

  // CTRL register image; job config bits are common to CLR and START writes.
  function automatic logic [31:0] ctrl_word(input logic mode, input logic relu,
                                            input logic bitsel, input logic clr,
                                            input logic start);
    logic [31:0] w;
    w = 32'h0;
    w[CTRL_START]  = start;
    w[CTRL_MODE]   = mode;
    w[CTRL_CLR]    = clr;
    w[CTRL_RELU]   = relu;
    w[CTRL_BITSEL] = bitsel;
    return w;
  endfunction

endpackage

// File: rtl/pe_dot_seq.sv
// Bus master that runs one dot-product job on the memory-mapped PE: program
// threshold, clear, stream A/B pairs with START/poll, then read the result.
module pe_dot_seq
  import pe_seq_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             job_valid_i,
  output logic             job_ready_o,
  input  logic [LEN_W-1:0] job_len_i,
  input  logic             cfg_mode_i,
  input  logic             cfg_relu_i,
  input  logic             cfg_bitsel_i,
  input  logic [23:0]      cfg_thresh_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [7:0]       op_a_i,
  input  logic [7:0]       op_b_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [23:0]      res_data_o,
  output logic             res_bit_o,
  output logic             res_err_o,
  output logic             busy_o,
  output logic             pe_req_o,
  output logic [3:0]       pe_wen_o,
  output logic [2:0]       pe_addr_o,
  output logic [31:0]      pe_wdata_o,
  input  logic [31:0]      pe_rdata_i
);

  localparam int PCW = $clog2(TIMEOUT + 1);

  state_e           state_q;
  logic [LEN_W-1:0] rem_q;
  logic             mode_q;
  logic             relu_q;
  logic             bitsel_q;
  logic [23:0]      thr_q;
  logic [7:0]       a_q;
  logic [7:0]       b_q;
  logic [PCW-1:0]   poll_q;
  logic [23:0]      data_q;
  logic             bit_q;
  logic             err_q;
  logic             live_q;

  logic unused_rdata;
  assign unused_rdata = ^pe_rdata_i[31:24];

  // live_q keeps job_ready_o low while reset is held and for the first edge after.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      mode_q   <= 1'b0;
      relu_q   <= 1'b0;
      bitsel_q <= 1'b0;
      thr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      poll_q   <= '0;
      data_q   <= '0;
      bit_q    <= 1'b0;
      err_q    <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      live_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (job_valid_i && live_q) begin
            rem_q    <= job_len_i;
            mode_q   <= cfg_mode_i;
            relu_q   <= cfg_relu_i;
            bitsel_q <= cfg_bitsel_i;
            thr_q    <= cfg_thresh_i;
            data_q   <= '0;
            bit_q    <= 1'b0;
            err_q    <= 1'b0;
            state_q  <= S_CFG;
          end
        end
        S_CFG:   state_q <= S_CLR;
        S_CLR:   state_q <= (rem_q == '0) ? S_RD_D : S_WAIT_OP;
        S_WAIT_OP: begin
          if (op_valid_i) begin
            a_q     <= op_a_i;
            b_q     <= op_b_i;
            state_q <= S_WR_A;
          end
        end
        S_WR_A:  state_q <= S_WR_B;
        S_WR_B:  state_q <= S_START;
        S_START: begin
          poll_q  <= '0;
          state_q <= S_POLL;
        end
        S_POLL: begin
          // A valid status on the last allowed poll still counts as success.
          if (pe_rdata_i[STATUS_VLD_BIT]) begin
            rem_q   <= rem_q - LEN_W'(1);
            state_q <= (rem_q == LEN_W'(1)) ? S_RD_D : S_WAIT_OP;
          end else if (poll_q == PCW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            rem_q   <= rem_q - LEN_W'(1);
            state_q <= S_DRAIN;
          end else begin
            poll_q <= poll_q + PCW'(1);
          end
        end
        S_DRAIN: begin
          if (rem_q == '0) begin
            state_q <= S_RESP;
          end else if (op_valid_i) begin
            rem_q <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) state_q <= S_RESP;
          end
        end
        S_RD_D: begin
          data_q  <= pe_rdata_i[23:0];
          state_q <= S_RD_B;
        end
        S_RD_B: begin
          bit_q   <= pe_rdata_i[0];
          state_q <= S_RESP;
        end
        S_RESP: begin
          if (res_ready_i) begin
            err_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Bus fields decode from registered state only, so reset clears them at once.
  always_comb begin
    pe_req_o   = 1'b0;
    pe_wen_o   = 4'b0000;
    pe_addr_o  = 3'd0;
    pe_wdata_o = 32'h0;
    case (state_q)
      S_CFG: begin
        pe_req_o   = 1'b1;
        pe_wen_o   = 4'b0111;
        pe_addr_o  = ADDR_THR;
        pe_wdata_o = {8'h00, thr_q};
      end
      S_CLR: begin
        pe_req_o   = 1'b1;
        pe_wen_o   = 4'b0001;
        pe_addr_o  = ADDR_CTRL;
        pe_wdata_o = ctrl_word(mode_q, relu_q, bitsel_q, 1'b1, 1'b0);
      end
      S_WR_A: begin
        pe_req_o   = 1'b1;
        pe_wen_o   = 4'b0001;
        pe_addr_o  = ADDR_A;
        pe_wdata_o = {24'h0, a_q};
      end
      S_WR_B: begin
        pe_req_o   = 1'b1;
        pe_wen_o   = 4'b0001;
        pe_addr_o  = ADDR_B;
        pe_wdata_o = {24'h0, b_q};
      end
      S_START: begin
        pe_req_o   = 1'b1;
        pe_wen_o   = 4'b0001;
        pe_addr_o  = ADDR_CTRL;
        pe_wdata_o = ctrl_word(mode_q, relu_q, bitsel_q, 1'b0, 1'b1);
      end
      S_POLL: begin
        pe_req_o  = 1'b1;
        pe_addr_o = ADDR_CTRL;
      end
      S_RD_D: begin
        pe_req_o  = 1'b1;
        pe_addr_o = ADDR_DATA;
      end
      S_RD_B: begin
        pe_req_o  = 1'b1;
        pe_addr_o = ADDR_BIT;
      end
      default: ;
    endcase
  end

  // DRAIN only takes pairs that still belong to the aborted job.
  assign op_ready_o  = (state_q == S_WAIT_OP) || ((state_q == S_DRAIN) && (rem_q != '0));
  assign job_ready_o = (state_q == S_IDLE) && live_q;
  assign busy_o      = (state_q != S_IDLE);
  assign res_valid_o = (state_q == S_RESP);
  assign res_data_o  = data_q;
  assign res_bit_o   = bit_q;
  assign res_err_o   = err_q;

endmodule

// File: tb/tb_pe_dot_seq.sv
// Bench for pe_dot_seq: a PE bus responder plus a transaction-list model of
// the expected bus traffic and result for each job.
module tb_pe_dot_seq;

  localparam int TO    = 4;
  localparam int LIMIT = 300;

  logic        clk;
  logic        rst_n;
  logic        job_valid_i;
  logic        job_ready_o;
  logic [7:0]  job_len_i;
  logic        cfg_mode_i, cfg_relu_i, cfg_bitsel_i;
  logic [23:0] cfg_thresh_i;
  logic        op_valid_i;
  logic        op_ready_o;
  logic [7:0]  op_a_i, op_b_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [23:0] res_data_o;
  logic        res_bit_o, res_err_o, busy_o;
  logic        pe_req_o;
  logic [3:0]  pe_wen_o;
  logic [2:0]  pe_addr_o;
  logic [31:0] pe_wdata_o;
  logic [31:0] pe_rdata;

  pe_dot_seq #(.LEN_W(8), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_len_i(job_len_i),
    .cfg_mode_i(cfg_mode_i), .cfg_relu_i(cfg_relu_i), .cfg_bitsel_i(cfg_bitsel_i),
    .cfg_thresh_i(cfg_thresh_i),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_a_i(op_a_i), .op_b_i(op_b_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .res_bit_o(res_bit_o), .res_err_o(res_err_o), .busy_o(busy_o),
    .pe_req_o(pe_req_o), .pe_wen_o(pe_wen_o), .pe_addr_o(pe_addr_o),
    .pe_wdata_o(pe_wdata_o), .pe_rdata_i(pe_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  pa [16];
  logic [7:0]  pb [16];
  logic [38:0] exp_q [$];
  logic [38:0] obs_q [$];
  logic [38:0] save_q [$];
  int          ready_cnt = 0;
  int          bus_bad = 0;

  // Responder: status bit8 rises on the k-th poll read after a START write.
  int          rsp_k = 1;
  bit          rsp_never = 1'b0;
  logic [23:0] rsp_data = 24'h0;
  logic        rsp_bit = 1'b0;
  int          polls_seen = 0;

  always_comb begin
    pe_rdata = 32'h0;
    if (pe_req_o && pe_wen_o == 4'h0) begin
      case (pe_addr_o)
        3'd2: begin
          pe_rdata = 32'h0000_005A;
          pe_rdata[8] = !rsp_never && (polls_seen + 1 >= rsp_k);
        end
        3'd4: pe_rdata = {8'hA5, rsp_data};
        3'd5: pe_rdata = {31'h2AAA_AAAA, rsp_bit};
        default: pe_rdata = 32'hDEAD_BEEF;
      endcase
    end
  end

  always @(posedge clk) begin
    if (pe_req_o && pe_wen_o != 4'h0 && pe_addr_o == 3'd2 && pe_wdata_o[0])
      polls_seen <= 0;
    else if (pe_req_o && pe_wen_o == 4'h0 && pe_addr_o == 3'd2)
      polls_seen <= polls_seen + 1;
  end

  always @(negedge clk) begin
    if (pe_req_o) obs_q.push_back({pe_wen_o, pe_addr_o, pe_wdata_o});
    else if (pe_wen_o != 4'h0 || pe_addr_o != 3'd0 || pe_wdata_o != 32'h0) bus_bad++;
    if (op_ready_o) ready_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic feed(input string tag, input int len, input int gap);
    for (int i = 0; i < len; i++) begin
      repeat (gap) @(negedge clk);
      op_valid_i = 1'b1;
      op_a_i = pa[i];
      op_b_i = pb[i];
      begin
        int n = 0;
        while (!op_ready_o && n < LIMIT) begin
          @(negedge clk);
          n++;
        end
        if (!op_ready_o) begin
          chk({tag, "_op_accept_timeout"}, 32'd0, 32'd1);
          op_valid_i = 1'b0;
          return;
        end
      end
      @(negedge clk);
      op_valid_i = 1'b0;
    end
  endtask

  task automatic wait_result(input string tag, input int hold, input logic [23:0] ed,
                             input logic eb, input logic ee);
    int n = 0;
    logic [23:0] sd;
    logic sb, se, stable, saw_ready;
    while (!res_valid_o && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid_o) begin
      chk({tag, "_res_timeout"}, 32'd0, 32'd1);
      return;
    end
    sd = res_data_o; sb = res_bit_o; se = res_err_o;
    stable = 1'b1; saw_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      job_valid_i = 1'b1;
      @(negedge clk);
      if (res_valid_o !== 1'b1 || res_data_o !== sd || res_bit_o !== sb || res_err_o !== se)
        stable = 1'b0;
      if (job_ready_o) saw_ready = 1'b1;
    end
    job_valid_i = 1'b0;
    if (hold > 0) chk({tag, "_hold_stable_noready"}, {30'h0, stable, saw_ready}, 32'd2);
    chk({tag, "_res_data"}, {8'h0, res_data_o}, {8'h0, ed});
    chk({tag, "_res_bit"}, {31'h0, res_bit_o}, {31'h0, eb});
    chk({tag, "_res_err"}, {31'h0, res_err_o}, {31'h0, ee});
    res_ready_i = 1'b1;
    @(negedge clk);
    res_ready_i = 1'b0;
    chk({tag, "_res_done"}, {31'h0, res_valid_o}, 32'd0);
  endtask

  task automatic start_job(input string tag, input int len, input bit mode, input bit relu,
                           input bit bitsel, input logic [23:0] thr);
    int n = 0;
    @(negedge clk);
    obs_q.delete();
    ready_cnt = 0;
    job_len_i = 8'(len);
    cfg_mode_i = mode; cfg_relu_i = relu; cfg_bitsel_i = bitsel; cfg_thresh_i = thr;
    job_valid_i = 1'b1;
    while (!job_ready_o && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (!job_ready_o) chk({tag, "_job_accept_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    job_valid_i = 1'b0;
  endtask

  task automatic run_job(input string tag, input int len, input bit mode, input bit relu,
                         input bit bitsel, input logic [23:0] thr, input int k, input bit never,
                         input int gap, input int hold, input logic [23:0] rd, input bit rb);
    logic [31:0] base;
    bit timed_out = 1'b0;
    int npoll, bad;
    base = 32'(bitsel) * 16 + 32'(relu) * 8 + 32'(mode) * 2;
    exp_q.delete();
    exp_q.push_back({4'b0111, 3'd3, 8'h00, thr});
    exp_q.push_back({4'b0001, 3'd2, base + 32'd4});
    for (int i = 0; i < len; i++) begin
      if (!timed_out) begin
        exp_q.push_back({4'b0001, 3'd0, 24'h0, pa[i]});
        exp_q.push_back({4'b0001, 3'd1, 24'h0, pb[i]});
        exp_q.push_back({4'b0001, 3'd2, base + 32'd1});
        npoll = (never || k > TO) ? TO : k;
        for (int p = 0; p < npoll; p++) exp_q.push_back({4'b0000, 3'd2, 32'h0});
        if (never || k > TO) timed_out = 1'b1;
      end
    end
    if (!timed_out) begin
      exp_q.push_back({4'b0000, 3'd4, 32'h0});
      exp_q.push_back({4'b0000, 3'd5, 32'h0});
    end
    rsp_k = k; rsp_never = never; rsp_data = rd; rsp_bit = rb;
    start_job(tag, len, mode, relu, bitsel, thr);
    fork
      feed(tag, len, gap);
      wait_result(tag, hold, timed_out ? 24'h0 : rd, timed_out ? 1'b0 : rb, timed_out);
    join
    chk({tag, "_bus_count"}, obs_q.size(), exp_q.size());
    bad = -1;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
    chk({tag, "_bus_first_bad_idx"}, bad, -1);
    if (len == 0) chk({tag, "_op_ready_never"}, ready_cnt, 0);
    $display("job %s len=%0d k=%0d never=%0d gap=%0d hold=%0d bus=%0d res=%h/%0d/%0d",
             tag, len, k, never, gap, hold, obs_q.size(), res_data_o, res_bit_o, timed_out);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;
    rst_n = 1'b0;
    job_valid_i = 1'b0; job_len_i = 8'h0;
    cfg_mode_i = 1'b0; cfg_relu_i = 1'b0; cfg_bitsel_i = 1'b0; cfg_thresh_i = 24'h0;
    op_valid_i = 1'b0; op_a_i = 8'h0; op_b_i = 8'h0; res_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pe_req", {31'h0, pe_req_o}, 32'd0);
    chk("rst_job_ready", {31'h0, job_ready_o}, 32'd0);
    chk("rst_busy", {31'h0, busy_o}, 32'd0);
    chk("rst_res_valid", {31'h0, res_valid_o}, 32'd0);
    chk("rst_op_ready", {31'h0, op_ready_o}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_job_ready", {31'h0, job_ready_o}, 32'd1);

    // Directed job: three pairs, status after two polls.
    pa[0] = 8'd3; pb[0] = 8'hFE;
    pa[1] = 8'd5; pb[1] = 8'd1;
    pa[2] = 8'd0; pb[2] = 8'd7;
    run_job("t1", 3, 1'b1, 1'b0, 1'b1, 24'h000010, 2, 1'b0, 0, 0, 24'hFFFFF7, 1'b1);
    save_q = obs_q;

    run_job("t2_len0", 0, 1'b0, 1'b1, 1'b0, 24'h123456, 1, 1'b0, 0, 0, 24'h0ABCDE, 1'b1);

    pa[0] = 8'd9; pb[0] = 8'h81;
    pa[1] = 8'd4; pb[1] = 8'h02;
    run_job("t3_timeout", 2, 1'b0, 1'b0, 1'b0, 24'hFFFFFF, 1, 1'b1, 0, 0, 24'h111111, 1'b1);

    pa[0] = 8'd200; pb[0] = 8'h80;
    run_job("t4_hold", 1, 1'b1, 1'b1, 1'b1, 24'h800000, 3, 1'b0, 0, 5, 24'h7FFFFF, 1'b0);

    // Reset in the middle of polling.
    rsp_never = 1'b1;
    pa[0] = 8'd1; pb[0] = 8'd1;
    start_job("t5", 1, 1'b0, 1'b0, 1'b0, 24'h000001);
    feed("t5", 1, 0);
    n = 0; found = 1'b0;
    while (!found && n < LIMIT) begin
      if (pe_req_o && pe_wen_o == 4'h0 && pe_addr_o == 3'd2) found = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("t5_reached_poll", {31'h0, found}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_req_drops", {31'h0, pe_req_o}, 32'd0);
    chk("t5_busy_drops", {31'h0, busy_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_idle_after", {30'h0, job_ready_o, busy_o}, 32'd2);
    pa[0] = 8'd7; pb[0] = 8'h10;
    pa[1] = 8'd8; pb[1] = 8'hF0;
    run_job("t5_after", 2, 1'b0, 1'b1, 1'b1, 24'h0000AA, 1, 1'b0, 0, 0, 24'h00C0DE, 1'b0);

    // Same work as the first job with gapped operands.
    pa[0] = 8'd3; pb[0] = 8'hFE;
    pa[1] = 8'd5; pb[1] = 8'd1;
    pa[2] = 8'd0; pb[2] = 8'd7;
    run_job("t6_gapped", 3, 1'b1, 1'b0, 1'b1, 24'h000010, 2, 1'b0, 2, 0, 24'hFFFFF7, 1'b1);
    chk("t6_same_count", obs_q.size(), save_q.size());
    n = -1;
    for (int i = 0; i < obs_q.size() && i < save_q.size(); i++)
      if (n < 0 && obs_q[i] !== save_q[i]) n = i;
    chk("t6_same_traffic", n, -1);

    for (int j = 0; j < 8; j++) begin
      int len, k, gap, hold;
      bit never, md, rl, bs, rb;
      logic [23:0] thr, rd;
      len = $urandom_range(0, 5);
      k = $urandom_range(1, TO);
      never = ($urandom_range(0, 3) == 0);
      gap = $urandom_range(0, 2);
      hold = $urandom_range(0, 3);
      md = 1'($urandom()); rl = 1'($urandom()); bs = 1'($urandom()); rb = 1'($urandom());
      thr = 24'($urandom()); rd = 24'($urandom());
      for (int i = 0; i < len; i++) begin
        pa[i] = 8'($urandom());
        pb[i] = 8'($urandom());
      end
      run_job($sformatf("rnd%0d", j), len, md, rl, bs, thr, k, never, gap, hold, rd, rb);
    end

    chk("idle_bus_zero", bus_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
